// File: rtl/regfile_dump_streamer_pkg.sv
// Shared configuration and types for the register-file dump/restore blocks.
// The restore-side writer imports the same beat layout, so a dump stream can
// be replayed without any repacking.
//   DTYPE_NBITS : width of one register
//   NREGS       : registers in the target file (power of two, >= 2)
//   ADDR_NBITS  : register address width
//   LEN_NBITS   : length field width, encodes 0..NREGS
package regfile_dump_streamer_pkg;

    localparam int DTYPE_NBITS = 8;
    localparam int NREGS       = 4;
    localparam int ADDR_NBITS  = $clog2(NREGS);
    localparam int LEN_NBITS   = ADDR_NBITS + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_NBITS-1:0]  addr;
        logic [DTYPE_NBITS-1:0] data;
        logic                   last;
    } beat_t;

    // Requests longer than the file would revisit registers; cap them at one pass.
    function automatic logic [LEN_NBITS-1:0] clamp_len(input logic [LEN_NBITS-1:0] len);
        logic [LEN_NBITS-1:0] max_len;
        max_len = LEN_NBITS'(NREGS);
        if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/regfile_dump_streamer_if.sv
// Bundle of the start/abort control, register-file read port and output
// beat stream of the dump streamer.
//   slave  : the streamer side (accepts starts, drives the read address and beats)
//   master : the surrounding system (issues starts, returns read data, consumes beats)
interface regfile_dump_streamer_if;
    import regfile_dump_streamer_pkg::*;

    logic                   start_call;
    logic                   start_rdy;
    logic [ADDR_NBITS-1:0]  start_base;
    logic [LEN_NBITS-1:0]   start_len;
    logic                   abort_call;
    logic [ADDR_NBITS-1:0]  rf_rd_addr;
    logic [DTYPE_NBITS-1:0] rf_rd_data;
    logic                   out_val;
    logic                   out_rdy;
    logic [ADDR_NBITS-1:0]  out_addr;
    logic [DTYPE_NBITS-1:0] out_data;
    logic                   out_last;
    logic                   done;

    modport slave (
        input  start_call, start_base, start_len, abort_call, rf_rd_data, out_rdy,
        output start_rdy, rf_rd_addr, out_val, out_addr, out_data, out_last, done
    );

    modport master (
        output start_call, start_base, start_len, abort_call, rf_rd_data, out_rdy,
        input  start_rdy, rf_rd_addr, out_val, out_addr, out_data, out_last, done
    );
endinterface

// File: rtl/regfile_dump_outbuf.sv
// Single-entry output register for the dump stream.
//   clk, reset  : clock, synchronous active-high reset
//   i_load      : capture i_beat and mark it valid
//   i_clear     : drop any held beat (abort)
//   i_beat      : beat to capture
//   i_rdy       : downstream accepts the held beat
//   o_val       : held beat is valid
//   o_beat      : held beat, stable while o_val=1 and i_rdy=0
//   o_can_load  : entry is empty or drains this cycle
module regfile_dump_outbuf
    import regfile_dump_streamer_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  i_load,
    input  logic  i_clear,
    input  beat_t i_beat,
    input  logic  i_rdy,
    output logic  o_val,
    output beat_t o_beat,
    output logic  o_can_load
);

    logic  r_val;
    beat_t r_beat;

    // Entry state: clear beats load, load beats drain, payload only moves on load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_val  <= 1'b0;
            r_beat <= {($bits(beat_t)){1'b0}};
        end else if (i_clear) begin
            r_val  <= 1'b0;
        end else if (i_load) begin
            r_val  <= 1'b1;
            r_beat <= i_beat;
        end else if (r_val && i_rdy) begin
            r_val  <= 1'b0;
        end else begin
            r_val  <= r_val;
        end
    end

    assign o_val      = r_val;
    assign o_beat     = r_beat;
    assign o_can_load = !r_val || i_rdy;

endmodule

// File: rtl/regfile_dump_streamer.sv
// Walks a wrapping range of register addresses through one read port and
// streams {addr, data, last} beats over val/rdy, then pulses done.
//   clk, reset : clock, synchronous active-high reset
//   bus        : control, read port and output stream (slave side)
module regfile_dump_streamer
    import regfile_dump_streamer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    regfile_dump_streamer_if.slave  bus
);

    localparam logic [LEN_NBITS-1:0]  LEN_ZERO = {LEN_NBITS{1'b0}};
    localparam logic [LEN_NBITS-1:0]  LEN_ONE  = LEN_NBITS'(1);
    localparam logic [ADDR_NBITS-1:0] ADDR_ONE = ADDR_NBITS'(1);

    state_e                 r_state, w_state_nxt;
    logic [ADDR_NBITS-1:0]  r_cur_addr, w_cur_addr_nxt;
    logic [LEN_NBITS-1:0]   r_remaining, w_remaining_nxt;
    logic                   r_done, w_done_nxt;
    logic                   w_issue;
    logic                   w_clear;
    logic                   w_can_load;
    logic                   w_out_val;
    beat_t                  w_beat_in;
    beat_t                  w_beat_out;

    // State, counters and done pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cur_addr  <= {ADDR_NBITS{1'b0}};
            r_remaining <= LEN_ZERO;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_addr  <= w_cur_addr_nxt;
            r_remaining <= w_remaining_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Next-state, counter update and beat issue decisions.
    always_comb begin
        w_state_nxt     = r_state;
        w_cur_addr_nxt  = r_cur_addr;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;
        w_issue         = 1'b0;
        w_clear         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A start wins over a simultaneous abort; abort alone is a no-op here.
                if (bus.start_call) begin
                    w_state_nxt     = ST_RUN;
                    w_cur_addr_nxt  = bus.start_base;
                    w_remaining_nxt = clamp_len(bus.start_len);
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.abort_call) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_issue = (r_remaining != LEN_ZERO) && w_can_load;
                    if (w_issue) begin
                        // Power-of-two NREGS: natural overflow is the wrap.
                        w_cur_addr_nxt  = r_cur_addr + ADDR_ONE;
                        w_remaining_nxt = r_remaining - LEN_ONE;
                    end else begin
                        w_cur_addr_nxt  = r_cur_addr;
                        w_remaining_nxt = r_remaining;
                    end
                    // Finished once the last beat leaves, or nothing was ever to be sent.
                    if ((w_out_val && bus.out_rdy && w_beat_out.last) ||
                        ((r_remaining == LEN_ZERO) && !w_out_val)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_beat_in.addr = r_cur_addr;
    assign w_beat_in.data = bus.rf_rd_data;
    assign w_beat_in.last = (r_remaining == LEN_ONE);

    regfile_dump_outbuf u_outbuf (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_issue),
        .i_clear    (w_clear),
        .i_beat     (w_beat_in),
        .i_rdy      (bus.out_rdy),
        .o_val      (w_out_val),
        .o_beat     (w_beat_out),
        .o_can_load (w_can_load)
    );

    assign bus.start_rdy  = (r_state == ST_IDLE);
    assign bus.rf_rd_addr = r_cur_addr;
    assign bus.out_val    = w_out_val;
    assign bus.out_addr   = w_beat_out.addr;
    assign bus.out_data   = w_beat_out.data;
    assign bus.out_last   = w_beat_out.last;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// Self-checking bench for regfile_dump_streamer: directed timing scenarios
// plus randomized dumps scored against an address/data list built from a
// shadow copy of the register file.
module tb_regfile_dump_streamer;

    localparam int NR = 4;

    logic clk;
    logic reset;

    regfile_dump_streamer_if bus();

    regfile_dump_streamer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file model: combinational read, clocked write.
    logic [7:0] mem [NR];
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    always @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end
    assign bus.rf_rd_data = mem[bus.rf_rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit last;
    } rec_t;

    rec_t acc_q[$];
    int   sh [NR];
    int   n_done;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record what the consumer takes this cycle, then advance to the next cycle.
    task automatic cyc();
        rec_t r;
        if (bus.out_val === 1'b1 && bus.out_rdy === 1'b1) begin
            r.addr = int'(bus.out_addr);
            r.data = int'(bus.out_data);
            r.last = bus.out_last;
            acc_q.push_back(r);
        end
        if (bus.done === 1'b1) n_done++;
        @(negedge clk);
    endtask

    task automatic rf_write(input int a, input int d);
        we = 1'b1; wa = 2'(a); wd = 8'(d);
        cyc();
        we = 1'b0;
        sh[a] = d;
    endtask

    // One complete dump checked against the expected beat list.
    task automatic run_dump(input int base, input int len, input bit rnd_rdy,
                            input bit with_abort, input string tag);
        int   exp_n;
        int   guard;
        bit   hold;
        int   pa, pd;
        acc_q.delete();
        n_done = 0;
        chk({tag, "_idle"}, bus.start_rdy, 1);
        bus.start_call = 1'b1;
        bus.abort_call = with_abort;
        bus.start_base = 2'(base);
        bus.start_len  = 3'(len);
        bus.out_rdy    = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc();
        bus.start_call = 1'b0;
        bus.abort_call = 1'b0;
        chk({tag, "_busy"}, bus.start_rdy, 0);
        guard = 0;
        while (n_done == 0 && guard < 200) begin
            bus.out_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = (bus.out_val === 1'b1) && !bus.out_rdy;
            pa = int'(bus.out_addr);
            pd = int'(bus.out_data);
            cyc();
            guard++;
            if (hold) begin
                chk({tag, "_stall_val"}, bus.out_val, 1);
                chk({tag, "_stall_beat"}, {bus.out_addr, bus.out_data}, {2'(pa), 8'(pd)});
            end
        end
        chk({tag, "_timeout"}, (guard < 200), 1);
        bus.out_rdy = 1'b1;
        cyc();
        exp_n = (len > NR) ? NR : len;
        chk({tag, "_nbeats"}, acc_q.size(), exp_n);
        chk({tag, "_ndone"}, n_done, 1);
        for (int i = 0; i < exp_n && i < acc_q.size(); i++) begin
            chk({tag, "_addr"}, acc_q[i].addr, (base + i) % NR);
            chk({tag, "_data"}, acc_q[i].data, sh[(base + i) % NR]);
            chk({tag, "_last"}, acc_q[i].last, (i == exp_n - 1));
        end
    endtask

    initial begin
        int old;
        reset = 1'b1;
        we = 1'b0; wa = 2'd0; wd = 8'd0;
        bus.start_call = 1'b0; bus.abort_call = 1'b0;
        bus.start_base = 2'd0; bus.start_len = 3'd0; bus.out_rdy = 1'b0;
        n_done = 0;
        for (int i = 0; i < NR; i++) sh[i] = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_val", bus.out_val, 0);
        chk("rst_outs", {bus.out_addr, bus.out_data, bus.out_last, bus.done}, 0);
        chk("rst_rdaddr", bus.rf_rd_addr, 0);
        chk("rst_start_rdy", bus.start_rdy, 1);
        reset = 1'b0;
        cyc();

        rf_write(0, 8'h11); rf_write(1, 8'h22); rf_write(2, 8'h33); rf_write(3, 8'h44);

        // Full dump with exact cycle timing.
        acc_q.delete(); n_done = 0;
        chk("t1_idle", bus.start_rdy, 1);
        bus.start_call = 1'b1; bus.start_base = 2'd0; bus.start_len = 3'd4; bus.out_rdy = 1'b1;
        cyc();
        bus.start_call = 1'b0;
        chk("t1_c1_rdy", bus.start_rdy, 0);
        chk("t1_c1_rdaddr", bus.rf_rd_addr, 0);
        chk("t1_c1_val", bus.out_val, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("t1_val", bus.out_val, 1);
            chk("t1_addr", bus.out_addr, i);
            chk("t1_data", bus.out_data, sh[i]);
            chk("t1_last", bus.out_last, (i == 3));
            chk("t1_busy", bus.start_rdy, 0);
            chk("t1_nodone", bus.done, 0);
            cyc();
        end
        chk("t1_done", bus.done, 1);
        chk("t1_c6_val", bus.out_val, 0);
        cyc();
        chk("t1_done_pulse", bus.done, 0);
        chk("t1_back_idle", bus.start_rdy, 1);

        // Wrapping range.
        run_dump(3, 3, 1'b0, 1'b0, "t2_wrap");

        // Back-pressure holds the beat and the read address.
        acc_q.delete(); n_done = 0;
        bus.start_call = 1'b1; bus.start_base = 2'd1; bus.start_len = 3'd2; bus.out_rdy = 1'b1;
        cyc();
        bus.start_call = 1'b0; bus.out_rdy = 1'b0;
        cyc();
        for (int c = 2; c <= 4; c++) begin
            chk("t3_hold_val", bus.out_val, 1);
            chk("t3_hold_beat", {bus.out_addr, bus.out_data, bus.out_last}, {2'd1, 8'h22, 1'b0});
            chk("t3_hold_rdaddr", bus.rf_rd_addr, 2);
            cyc();
        end
        bus.out_rdy = 1'b1;
        chk("t3_c5_beat", {bus.out_val, bus.out_addr, bus.out_data}, {1'b1, 2'd1, 8'h22});
        cyc();
        chk("t3_c6_beat", {bus.out_val, bus.out_addr, bus.out_data, bus.out_last},
            {1'b1, 2'd2, 8'h33, 1'b1});
        cyc();
        chk("t3_done", bus.done, 1);
        chk("t3_c7_val", bus.out_val, 0);
        cyc();
        chk("t3_nbeats", acc_q.size(), 2);

        // Zero-length dump.
        acc_q.delete(); n_done = 0;
        bus.start_call = 1'b1; bus.start_base = 2'd2; bus.start_len = 3'd0;
        cyc();
        bus.start_call = 1'b0;
        chk("t4_c1", {bus.start_rdy, bus.out_val, bus.done}, 3'b000);
        cyc();
        chk("t4_c2", {bus.start_rdy, bus.out_val, bus.done}, 3'b101);
        cyc();
        chk("t4_nbeats", acc_q.size(), 0);

        // Over-long request is clamped.
        run_dump(2, 7, 1'b0, 1'b0, "t4_clamp");

        // Abort while the second beat is stalled.
        acc_q.delete(); n_done = 0;
        bus.start_call = 1'b1; bus.start_base = 2'd0; bus.start_len = 3'd4; bus.out_rdy = 1'b1;
        cyc();
        bus.start_call = 1'b0;
        cyc();
        cyc();
        bus.out_rdy = 1'b0; bus.abort_call = 1'b1;
        chk("t5_beat2", {bus.out_val, bus.out_addr}, {1'b1, 2'd1});
        cyc();
        bus.abort_call = 1'b0;
        chk("t5_after", {bus.out_val, bus.start_rdy, bus.done}, 3'b010);
        cyc();
        chk("t5_nodone", bus.done, 0);
        chk("t5_nbeats", acc_q.size(), 1);
        run_dump(2, 3, 1'b1, 1'b0, "t5_restart");
        run_dump(1, 2, 1'b0, 1'b1, "t5_start_abort");

        // Same-cycle write is not seen by the beat issued in that cycle.
        acc_q.delete(); n_done = 0;
        old = sh[1];
        bus.start_call = 1'b1; bus.start_base = 2'd1; bus.start_len = 3'd1; bus.out_rdy = 1'b1;
        cyc();
        bus.start_call = 1'b0;
        we = 1'b1; wa = 2'd1; wd = 8'h99;
        cyc();
        we = 1'b0; sh[1] = 8'h99;
        chk("t6_old_data", {bus.out_val, bus.out_data}, {1'b1, 8'(old)});
        cyc();
        chk("t6_done", bus.done, 1);
        cyc();
        run_dump(1, 1, 1'b0, 1'b0, "t6_new_data");

        // Reset in the middle of a stalled dump.
        bus.start_call = 1'b1; bus.start_base = 2'd0; bus.start_len = 3'd4; bus.out_rdy = 1'b0;
        cyc();
        bus.start_call = 1'b0;
        cyc(); cyc();
        chk("t7_pre_val", bus.out_val, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t7_rst_outs", {bus.out_val, bus.out_addr, bus.out_data, bus.out_last, bus.done}, 0);
        chk("t7_rst_idle", {bus.start_rdy, bus.rf_rd_addr}, {1'b1, 2'd0});
        cyc();
        chk("t7_nodone", bus.done, 0);

        // Randomized dumps with random back-pressure and occasional register updates.
        for (int it = 0; it < 16; it++) begin
            if (it % 4 == 0) rf_write($urandom_range(0, NR - 1), $urandom_range(0, 255));
            run_dump($urandom_range(0, NR - 1), $urandom_range(0, 7), 1'b1, 1'b0, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
